// File: rtl/ps2_host_tx.sv
// ============================================================================
//  Module   : ps2_host_tx
//  Purpose  : Host-to-device PS/2 transmitter (request-to-send, framed byte
//             shift-out on device clock edges, acknowledge sampling).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_INHIBIT   = 3'd1;
    localparam logic [2:0] S_START     = 3'd2;
    localparam logic [2:0] S_SEND      = 3'd3;
    localparam logic [2:0] S_ACK       = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    // Line synchronizers; idle lines are high, so reset to 1.
    logic [1:0] clk_sync_q;
    logic [1:0] dat_sync_q;
    logic       clk_prev_q;
    logic       clk_s;
    logic       dat_s;
    logic       clk_fall;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    assign clk_s    = clk_sync_q[1];
    assign dat_s    = dat_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [9:0]       shift_q,   shift_d;
    logic             cur_bit_q, cur_bit_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic             err_q,     err_d;

    logic tx_ready_q, tx_ready_d;
    logic busy_q,     busy_d;
    logic done_q,     done_d;
    logic ack_err_q,  ack_err_d;
    logic timeout_q,  timeout_d;
    logic clk_oe_q,   clk_oe_d;
    logic dat_oe_q,   dat_oe_d;

    logic accept;
    logic timed_out;

    assign accept    = tx_valid & tx_ready_q;
    assign timed_out = ((state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE))
                       && (cnt_q == TIMEOUT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        cur_bit_d = cur_bit_q;
        bit_idx_d = bit_idx_q;
        err_d     = err_q;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    shift_d = {1'b1, ~^tx_data, tx_data};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_START: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                cur_bit_d = 1'b0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                cnt_d = cnt_q + CNT_ONE;
                // Each device falling edge presents the next frame bit.
                if (clk_fall) begin
                    cur_bit_d = shift_q[0];
                    shift_d   = {1'b1, shift_q[9:1]};
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + CNT_ONE;
                if (clk_fall) begin
                    err_d   = dat_s;
                    state_d = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (clk_s && dat_s) begin
                    done_d    = 1'b1;
                    ack_err_d = err_q;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides any edge or completion seen in the same cycle.
        if (timed_out) begin
            state_d   = S_IDLE;
            done_d    = 1'b0;
            ack_err_d = 1'b0;
            timeout_d = 1'b1;
        end

        // Ready returns one cycle after the completion/abort pulse.
        tx_ready_d = (state_d == S_IDLE) && !done_d && !timeout_d;
        busy_d     = !tx_ready_d;
        clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_START);
        dat_oe_d   = (state_d == S_START) || ((state_d == S_SEND) && !cur_bit_d);
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            cur_bit_q  <= 1'b0;
            bit_idx_q  <= '0;
            err_q      <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            cur_bit_q  <= cur_bit_d;
            bit_idx_q  <= bit_idx_d;
            err_q      <= err_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
        end
    end

    assign tx_ready   = tx_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ack_err    = ack_err_q;
    assign timeout    = timeout_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ============================================================================
//  Module   : tb_ps2_host_tx
//  Purpose  : Self-checking bench for ps2_host_tx with a behavioural device.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_host_tx;

    localparam int INH      = 50;
    localparam int TO_MAIN  = 4000;
    localparam int TO_SHORT = 200;
    localparam int HALF     = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    int tests = 0;
    int fails = 0;

    // Main instance, connected to the device model
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic tx_ready, busy, done, ack_err, timeout, clk_oe, dat_oe;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic line_clk, line_dat;
    assign line_clk = clk_oe ? 1'b0 : dev_clk;
    assign line_dat = dat_oe ? 1'b0 : dev_dat;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO_MAIN)) u_dut (
        .CLOCK_50(clk), .reset_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .done(done), .ack_err(ack_err),
        .timeout(timeout), .ps2_clk_in(line_clk), .ps2_dat_in(line_dat),
        .ps2_clk_oe(clk_oe), .ps2_dat_oe(dat_oe)
    );

    // Second instance with no device attached
    logic [7:0] to_tx_data  = 8'h00;
    logic       to_tx_valid = 1'b0;
    logic to_tx_ready, to_busy, to_done, to_ack_err, to_timeout, to_clk_oe, to_dat_oe;
    logic to_line_clk, to_line_dat;
    assign to_line_clk = ~to_clk_oe;
    assign to_line_dat = ~to_dat_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO_SHORT)) u_dut_to (
        .CLOCK_50(clk), .reset_n(rst_n), .tx_data(to_tx_data), .tx_valid(to_tx_valid),
        .tx_ready(to_tx_ready), .busy(to_busy), .done(to_done), .ack_err(to_ack_err),
        .timeout(to_timeout), .ps2_clk_in(to_line_clk), .ps2_dat_in(to_line_dat),
        .ps2_clk_oe(to_clk_oe), .ps2_dat_oe(to_dat_oe)
    );

    int done_cnt = 0;
    int timeout_cnt = 0;
    int to_done_cnt = 0;
    always @(negedge clk) begin
        if (done === 1'b1)    done_cnt++;
        if (timeout === 1'b1) timeout_cnt++;
        if (to_done === 1'b1) to_done_cnt++;
    end

    // Expected frame as seen on the wire: start, data LSB first, odd parity, stop
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] r;
        int ones;
        ones = 0;
        r[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r[i+1] = b[i];
            ones  += int'(b[i]);
        end
        r[9]  = (ones % 2 == 0);
        r[10] = 1'b1;
        return r;
    endfunction

    task automatic issue(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: samples DAT late in each high phase, then pulls CLK low.
    task automatic device_run(input logic ack, input int hold, output logic [10:0] seen, output int bad);
        bad  = 0;
        seen = '0;
        for (int k = 0; k < 11; k++) begin
            repeat (HALF - 5) @(negedge clk);
            seen[k] = line_dat;
            if (k == 10 && ack) dev_dat = 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k == 10) begin
                dev_dat = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    if (busy !== 1'b1 || done !== 1'b0) bad++;
                end
            end
            dev_clk = 1'b1;
        end
    endtask

    // Called on the first negedge after acceptance.
    task automatic frame_after_accept(input logic ack, input int hold, output logic [10:0] seen,
                                      output int inh, output bit start_ok, output bit send_ok,
                                      output int bad);
        inh = 0;
        while (clk_oe === 1'b1 && dat_oe === 1'b0 && inh < INH * 4) begin
            inh++;
            @(negedge clk);
        end
        start_ok = (clk_oe === 1'b1 && dat_oe === 1'b1);
        @(negedge clk);
        send_ok = (clk_oe === 1'b0 && dat_oe === 1'b1);
        device_run(ack, hold, seen, bad);
    endtask

    task automatic wait_done(output bit got, output logic aerr);
        got  = 1'b0;
        aerr = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got  = 1'b1;
                aerr = ack_err;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_ready, busy, done, ack_err, timeout, clk_oe, dat_oe} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_main: got %b want 1000000", {tx_ready, busy, done, ack_err, timeout, clk_oe, dat_oe});
        end
        tests++;
        if ({to_tx_ready, to_busy, to_done, to_ack_err, to_timeout, to_clk_oe, to_dat_oe} !== 7'b1000000) begin
            fails++;
            $display("FAIL reset_to: got %b want 1000000", {to_tx_ready, to_busy, to_done, to_ack_err, to_timeout, to_clk_oe, to_dat_oe});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if ({tx_ready, busy, clk_oe, dat_oe} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_release: got %b want 1000", {tx_ready, busy, clk_oe, dat_oe});
        end
    endtask

    task automatic test_ed_ack();
        logic [10:0] seen; int inh; bit sok, dok, got; int bad; logic aerr;
        issue(8'hED);
        tests++;
        if ({clk_oe, busy, tx_ready} !== 3'b110) begin
            fails++;
            $display("FAIL ed_accept: clk_oe/busy/ready=%b want 110", {clk_oe, busy, tx_ready});
        end
        frame_after_accept(1'b1, 0, seen, inh, sok, dok, bad);
        tests++;
        if (inh !== INH) begin
            fails++;
            $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH);
        end
        tests++;
        if (!sok || !dok) begin
            fails++;
            $display("FAIL ed_start_bit: start=%0d send=%0d want 1 1", sok, dok);
        end
        tests++;
        if (seen !== 11'b11111011010) begin
            fails++;
            $display("FAIL ed_frame: got %b want %b", seen, 11'b11111011010);
        end
        wait_done(got, aerr);
        tests++;
        if (!got || aerr !== 1'b0) begin
            fails++;
            $display("FAIL ed_done: done=%0d ack_err=%b want 1 0", got, aerr);
        end
        @(negedge clk);
        tests++;
        if ({tx_ready, done, busy} !== 3'b100) begin
            fails++;
            $display("FAIL ed_after_done: ready/done/busy=%b want 100", {tx_ready, done, busy});
        end
    endtask

    task automatic test_f4_nack();
        logic [10:0] seen; int inh; bit sok, dok, got; int bad; logic aerr;
        issue(8'hF4);
        frame_after_accept(1'b0, 0, seen, inh, sok, dok, bad);
        tests++;
        if (seen[9] !== 1'b0 || seen !== frame_of(8'hF4)) begin
            fails++;
            $display("FAIL f4_frame: got %b want %b", seen, frame_of(8'hF4));
        end
        wait_done(got, aerr);
        tests++;
        if (!got || aerr !== 1'b1) begin
            fails++;
            $display("FAIL f4_nack: done=%0d ack_err=%b want 1 1", got, aerr);
        end
    endtask

    task automatic test_timeout();
        int c; int d0;
        d0 = to_done_cnt;
        @(negedge clk);
        to_tx_data  = 8'($urandom);
        to_tx_valid = 1'b1;
        @(negedge clk);
        to_tx_valid = 1'b0;
        c = 0;
        while (!(to_clk_oe === 1'b1 && to_dat_oe === 1'b1) && c < INH * 4) begin
            c++;
            @(negedge clk);
        end
        @(negedge clk);
        c = 0;
        while (to_timeout !== 1'b1 && c < TO_SHORT * 2) begin
            c++;
            @(negedge clk);
        end
        tests++;
        if (c !== TO_SHORT) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles want %0d", c, TO_SHORT);
        end
        tests++;
        if ({to_clk_oe, to_dat_oe, to_tx_ready} !== 3'b000) begin
            fails++;
            $display("FAIL timeout_lines: clk_oe/dat_oe/ready=%b want 000", {to_clk_oe, to_dat_oe, to_tx_ready});
        end
        @(negedge clk);
        tests++;
        if ({to_tx_ready, to_timeout, to_busy} !== 3'b100 || to_done_cnt !== d0) begin
            fails++;
            $display("FAIL timeout_after: ready/timeout/busy=%b dones=%0d want 100 0",
                     {to_tx_ready, to_timeout, to_busy}, to_done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] seen; int inh; bit sok, dok, got; int bad; logic aerr;
        @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'($urandom) | 8'h01;
        frame_after_accept(1'b1, 0, seen, inh, sok, dok, bad);
        tests++;
        if (seen !== frame_of(8'h00) || seen[9] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first_frame: got %b want %b", seen, frame_of(8'h00));
        end
        tx_data = 8'hFF;
        wait_done(got, aerr);
        tests++;
        if (!got || tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first_done: done=%0d ready=%b want 1 0", got, tx_ready);
        end
        @(negedge clk);
        tests++;
        if ({tx_ready, clk_oe} !== 2'b10) begin
            fails++;
            $display("FAIL b2b_gap: ready/clk_oe=%b want 10", {tx_ready, clk_oe});
        end
        @(negedge clk);
        tests++;
        if ({tx_ready, clk_oe} !== 2'b01) begin
            fails++;
            $display("FAIL b2b_second_accept: ready/clk_oe=%b want 01", {tx_ready, clk_oe});
        end
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        frame_after_accept(1'b1, 0, seen, inh, sok, dok, bad);
        tests++;
        if (seen !== frame_of(8'hFF) || seen[9] !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_frame: got %b want %b", seen, frame_of(8'hFF));
        end
        wait_done(got, aerr);
        tests++;
        if (!got || aerr !== 1'b0) begin
            fails++;
            $display("FAIL b2b_second_done: done=%0d ack_err=%b want 1 0", got, aerr);
        end
    endtask

    task automatic test_wait_idle();
        logic [10:0] seen; int inh; bit sok, dok, got; int bad; logic aerr;
        issue(8'hFF);
        frame_after_accept(1'b1, 500, seen, inh, sok, dok, bad);
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL wait_idle_hold: %0d bad cycles want 0", bad);
        end
        wait_done(got, aerr);
        tests++;
        if (!got || aerr !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle_done: done=%0d ack_err=%b want 1 0", got, aerr);
        end
    endtask

    task automatic test_random();
        logic [10:0] seen; int inh; bit sok, dok, got; int bad; logic aerr;
        logic [7:0] b; logic ack;
        for (int n = 0; n < 4; n++) begin
            b   = 8'($urandom);
            ack = 1'($urandom);
            issue(b);
            frame_after_accept(ack, 0, seen, inh, sok, dok, bad);
            tests++;
            if (seen !== frame_of(b)) begin
                fails++;
                $display("FAIL rand_frame[%0d]: byte %h got %b want %b", n, b, seen, frame_of(b));
            end
            wait_done(got, aerr);
            tests++;
            if (!got || aerr !== !ack) begin
                fails++;
                $display("FAIL rand_done[%0d]: done=%0d ack_err=%b want 1 %b", n, got, aerr, !ack);
            end
        end
    endtask

    task automatic test_reset_mid_send();
        int c; int bad; int d0; int t0;
        issue(8'($urandom));
        c = 0;
        while (!(clk_oe === 1'b1 && dat_oe === 1'b1) && c < INH * 4) begin
            c++;
            @(negedge clk);
        end
        @(negedge clk);
        tests++;
        if ({clk_oe, dat_oe} !== 2'b01) begin
            fails++;
            $display("FAIL rst_pre_send: clk_oe/dat_oe=%b want 01", {clk_oe, dat_oe});
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({clk_oe, dat_oe} !== 2'b00) begin
            fails++;
            $display("FAIL rst_async_oe: clk_oe/dat_oe=%b want 00", {clk_oe, dat_oe});
        end
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        t0 = timeout_cnt;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_ready !== 1'b1 || busy !== 1'b0 || ack_err !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0 || done_cnt !== d0 || timeout_cnt !== t0) begin
            fails++;
            $display("FAIL rst_after: bad=%0d dones=%0d timeouts=%0d want 0 0 0",
                     bad, done_cnt - d0, timeout_cnt - t0);
        end
    endtask

    initial begin
        test_reset();
        test_ed_ack();
        test_f4_nack();
        test_timeout();
        test_back_to_back();
        test_wait_idle();
        test_random();
        test_reset_mid_send();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule

`default_nettype wire
